reel_spin_controller: RTL

- Sequences the slot machine's reels through one spin. Consumes single-cycle button pulses from the edge detectors on the start and stop switches.
- Advances reel symbol positions on a prescaled tick and stops reels one at a time in order 0..NUM_REELS-1.
- Reports a one-cycle result strobe with a win flag. Sits between the switch edge-detect stage and the reel display and payout logic.

---
 rtl/reel_spin_controller_if.sv | 35 +++
 rtl/reel_spin_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reel_spin_controller_if.sv
// rtl/reel_spin_controller_if.sv - button/result bundle between switch edge detectors, reel controller and display/payout
//
// Purpose: groups the spin controller's pulse inputs and reel/result outputs.
// Signals:
//   start_pulse   : single-cycle start-button pulse (to controller)
//   stop_pulse    : single-cycle stop-button pulse (to controller)
//   reel_pos      : NUM_REELS*SYM_W concatenated reel positions, reel 0 in LSBs
//   reel_spinning : bit i high while reel i advances
//   busy          : high while a spin is in progress
//   result_valid  : one-cycle strobe when the last reel stops
//   win           : all reel positions equal, valid from result_valid onward
// Modports: master drives the pulses (switch side), slave is the controller.

interface reel_spin_controller_if #(
  parameter int NUM_REELS = 3,
  parameter int SYM_W     = 3
);
  logic                       start_pulse;
  logic                       stop_pulse;
  logic [NUM_REELS*SYM_W-1:0] reel_pos;
  logic [NUM_REELS-1:0]       reel_spinning;
  logic                       busy;
  logic                       result_valid;
  logic                       win;

  modport master (
    output start_pulse, stop_pulse,
    input  reel_pos, reel_spinning, busy, result_valid, win
  );

  modport slave (
    input  start_pulse, stop_pulse,
    output reel_pos, reel_spinning, busy, result_valid, win
  );
endinterface

// File: rtl/reel_spin_controller.sv
// rtl/reel_spin_controller.sv - sequences slot reels through one spin and reports the result
//
// Purpose: on start, all reels advance one symbol per prescaled tick; reels
// stop one at a time in index order, either on an eligible stop pulse or
// after AUTO_TICKS ticks without a stop. When the last reel stops a
// one-cycle result strobe is issued together with the win flag.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : reel_spin_controller_if.slave (pulses in, reel state/result out)

module reel_spin_controller #(
  parameter int NUM_REELS   = 3,
  parameter int NUM_SYMBOLS = 8,
  parameter int SYM_W       = 3,
  parameter int STEP_DIV    = 4,
  parameter int MIN_TICKS   = 4,
  parameter int AUTO_TICKS  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  reel_spin_controller_if.slave  bus
);

  localparam int IDX_W  = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;
  localparam int PRE_W  = $clog2(STEP_DIV);
  localparam int MIN_W  = $clog2(MIN_TICKS + 1);
  localparam int AUTO_W = $clog2(AUTO_TICKS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SPIN = 1'b1
  } state_t;

  state_t                          r_state, w_state_nxt;
  logic [PRE_W-1:0]                r_presc, w_presc_nxt;
  logic [MIN_W-1:0]                r_min_cnt, w_min_cnt_nxt;
  logic [AUTO_W-1:0]               r_auto_cnt, w_auto_cnt_nxt;
  logic [IDX_W-1:0]                r_stop_idx, w_stop_idx_nxt;
  logic [NUM_REELS-1:0][SYM_W-1:0] r_pos, w_pos_nxt;
  logic [NUM_REELS-1:0]            r_spinning, w_spinning_nxt;
  logic                            r_busy, w_busy_nxt;
  logic                            r_result_valid, w_result_valid_nxt;
  logic                            r_win, w_win_nxt;

  logic                            w_tick;
  logic                            w_eligible;
  logic                            w_stop;
  logic [NUM_REELS-1:0]            w_stop_mask;
  logic                            w_all_eq;

  assign w_tick      = (r_state == SPIN) && (r_presc == PRE_W'(STEP_DIV - 1));
  assign w_eligible  = (r_min_cnt == MIN_W'(MIN_TICKS));
  // A manual stop and an auto-stop in the same cycle collapse into one stop.
  assign w_stop      = (r_state == SPIN) &&
                       ((bus.stop_pulse && w_eligible) ||
                        (r_auto_cnt == AUTO_W'(AUTO_TICKS)));
  assign w_stop_mask = NUM_REELS'(1) << r_stop_idx;

  // Reel advance; the reel being stopped on a tick edge holds its position.
  always_comb begin
    w_pos_nxt = r_pos;
    for (int i = 0; i < NUM_REELS; i++) begin
      if (w_tick && r_spinning[i] && !(w_stop && w_stop_mask[i])) begin
        if (r_pos[i] == SYM_W'(NUM_SYMBOLS - 1)) begin
          w_pos_nxt[i] = '0;
        end else begin
          w_pos_nxt[i] = r_pos[i] + SYM_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_all_eq = 1'b1;
    for (int i = 1; i < NUM_REELS; i++) begin
      if (w_pos_nxt[i] != w_pos_nxt[0]) begin
        w_all_eq = 1'b0;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt        = r_state;
    w_presc_nxt        = r_presc;
    w_min_cnt_nxt      = r_min_cnt;
    w_auto_cnt_nxt     = r_auto_cnt;
    w_stop_idx_nxt     = r_stop_idx;
    w_spinning_nxt     = r_spinning;
    w_busy_nxt         = r_busy;
    w_result_valid_nxt = 1'b0;
    w_win_nxt          = r_win;

    case (r_state)
      IDLE: begin
        if (bus.start_pulse) begin
          w_state_nxt    = SPIN;
          w_spinning_nxt = '1;
          w_busy_nxt     = 1'b1;
          w_win_nxt      = 1'b0;
          w_presc_nxt    = '0;
          w_min_cnt_nxt  = '0;
          w_auto_cnt_nxt = '0;
          w_stop_idx_nxt = '0;
        end
      end

      SPIN: begin
        w_presc_nxt = w_tick ? '0 : r_presc + PRE_W'(1);

        if (w_tick && !w_eligible) begin
          w_min_cnt_nxt = r_min_cnt + MIN_W'(1);
        end

        if (w_stop) begin
          w_spinning_nxt = r_spinning & ~w_stop_mask;
          w_auto_cnt_nxt = '0;
          if (r_stop_idx == IDX_W'(NUM_REELS - 1)) begin
            w_state_nxt        = IDLE;
            w_busy_nxt         = 1'b0;
            w_result_valid_nxt = 1'b1;
            w_win_nxt          = w_all_eq;
            w_stop_idx_nxt     = '0;
          end else begin
            w_stop_idx_nxt = r_stop_idx + IDX_W'(1);
          end
        end else if (w_tick) begin
          w_auto_cnt_nxt = r_auto_cnt + AUTO_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_presc        <= '0;
      r_min_cnt      <= '0;
      r_auto_cnt     <= '0;
      r_stop_idx     <= '0;
      r_pos          <= '0;
      r_spinning     <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_win          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_presc        <= w_presc_nxt;
      r_min_cnt      <= w_min_cnt_nxt;
      r_auto_cnt     <= w_auto_cnt_nxt;
      r_stop_idx     <= w_stop_idx_nxt;
      r_pos          <= w_pos_nxt;
      r_spinning     <= w_spinning_nxt;
      r_busy         <= w_busy_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_win          <= w_win_nxt;
    end
  end

  assign bus.reel_pos      = r_pos;
  assign bus.reel_spinning = r_spinning;
  assign bus.busy          = r_busy;
  assign bus.result_valid  = r_result_valid;
  assign bus.win           = r_win;

endmodule
